// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// All segment and anode values are active-low.
package seg7_pkg;

    typedef enum logic {
        GUARD  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [3:0] AN_OFF   = 4'b1111;

    // Bit order is {g,f,e,d,c,b,a}; entry N is the pattern for decimal digit N.
    localparam logic [9:0][6:0] DIGIT_PAT = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Data/display bundle between the BCD source and the scan driver.
interface seg7_scan_driver_if;
    logic [9:0] bcd_in;
    logic       load;
    logic       blank_lz;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    modport master (output bcd_in, load, blank_lz, input an, seg, dp, frame_done);
    modport slave  (input bcd_in, load, blank_lz, output an, seg, dp, frame_done);
endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low segment decode; 10..15 render as a dash.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (digit <= 4'd9) seg = DIGIT_PAT[digit];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode scan driver: guard/active slot FSM, per-slot digit latch,
// optional leading-zero blanking. All outputs are registered from next-state values.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_driver_if.slave  bus
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] GUARD_LAST  = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ACTIVE_LAST = CW'(REFRESH_DIV - BLANK_CYCLES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [9:0]    pending, pending_nxt;
    logic [9:0]    shown, shown_nxt;
    logic          frame_nxt;
    logic [3:0]    digit;
    logic          blanked;
    logic [6:0]    dec_seg;
    logic [3:0]    an_nxt, an_q;
    logic [6:0]    seg_nxt, seg_q;
    logic          frame_q;

    seg7_decoder u_decoder (
        .digit (digit),
        .seg   (dec_seg)
    );

    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        idx_nxt     = idx;
        frame_nxt   = 1'b0;
        pending_nxt = bus.load ? bus.bcd_in : pending;
        shown_nxt   = shown;

        case (state)
            GUARD: begin
                if (cnt == GUARD_LAST) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = '0;
                end
            end
            ACTIVE: begin
                if (cnt == ACTIVE_LAST) begin
                    state_nxt = GUARD;
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 2'd1;
                    frame_nxt = (idx == 2'd3);
                    // Taking pending_nxt gives the same-edge load bypass for free.
                    shown_nxt = pending_nxt;
                end
            end
            default: state_nxt = GUARD;
        endcase

        digit   = 4'd0;
        blanked = 1'b1;
        case (idx_nxt)
            2'd0: begin
                digit   = shown_nxt[3:0];
                blanked = 1'b0;
            end
            2'd1: begin
                digit   = shown_nxt[7:4];
                blanked = bus.blank_lz && (shown_nxt[9:4] == 6'd0);
            end
            2'd2: begin
                digit   = {2'b00, shown_nxt[9:8]};
                blanked = bus.blank_lz && (shown_nxt[9:8] == 2'd0);
            end
            default: ;
        endcase

        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
        if (state_nxt == ACTIVE && !blanked) begin
            an_nxt  = ~(4'b0001 << idx_nxt);
            seg_nxt = dec_seg;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= GUARD;
            cnt     <= '0;
            idx     <= '0;
            pending <= '0;
            shown   <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            frame_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            pending <= pending_nxt;
            shown   <= shown_nxt;
            an_q    <= an_nxt;
            seg_q   <= seg_nxt;
            frame_q <= frame_nxt;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = 1'b1;
    assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver (REFRESH_DIV=8, BLANK_CYCLES=2).
// Expected per-cycle display words are queued with each stimulus step and popped at every negedge.
module tb_seg7_scan_driver;

    localparam logic [6:0] P0   = 7'b1000000;
    localparam logic [6:0] P1   = 7'b1111001;
    localparam logic [6:0] P2   = 7'b0100100;
    localparam logic [6:0] P3   = 7'b0110000;
    localparam logic [6:0] P5   = 7'b0010010;
    localparam logic [6:0] P7   = 7'b1111000;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] OFF  = 7'b1111111;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
        bit         seg_care;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   sample     = 0;

    always #5 clk = ~clk;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: an_seg_dp_fd got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic push_slot(input logic [3:0] an_e, input logic [6:0] seg_e, input logic fd_first);
        exp_t e;
        e.an = 4'hF; e.seg = OFF; e.fd = fd_first; e.seg_care = 1'b1;
        sb.push_back(e);
        e.fd = 1'b0;
        sb.push_back(e);
        e.an = an_e; e.seg = seg_e; e.seg_care = (an_e != 4'hF);
        repeat (6) sb.push_back(e);
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input logic b1, input logic b2, input logic fd);
        push_slot(4'b1110, s0, fd);
        push_slot(b1 ? 4'b1111 : 4'b1101, s1, 1'b0);
        push_slot(b2 ? 4'b1111 : 4'b1011, s2, 1'b0);
        push_slot(4'b1111, OFF, 1'b0);
    endtask

    // Blanked digits only have their anodes checked; segments are don't-care there.
    task automatic drain(input int n);
        exp_t       e;
        logic [6:0] seg_obs;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                check($sformatf("sb_empty%0d", sample), 13'h0, 13'h1);
            end else begin
                e       = sb.pop_front();
                seg_obs = e.seg_care ? bus.seg : e.seg;
                check($sformatf("sample%0d", sample),
                      {bus.an, seg_obs, bus.dp, bus.frame_done},
                      {e.an, e.seg, 1'b1, e.fd});
            end
            bus.load = 1'b0;
            sample++;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.bcd_in   = 10'd0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_state", {bus.an, bus.seg, bus.dp, bus.frame_done}, {4'hF, OFF, 1'b1, 1'b0});
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Idle after reset: all digits zero, no frame pulse on the first slot.
        push_frame(P0, P0, P0, 1'b0, 1'b0, 1'b0);
        drain(32);

        // 255 loaded on the guard-entry edge goes straight to the display.
        push_frame(P5, P5, P2, 1'b0, 1'b0, 1'b1);
        bus.bcd_in = 10'b10_0101_0101;
        bus.load   = 1'b1;
        drain(32);

        // 7 with leading-zero blanking: only ones lit.
        push_frame(P7, OFF, OFF, 1'b1, 1'b1, 1'b1);
        bus.bcd_in   = 10'b00_0000_0111;
        bus.load     = 1'b1;
        bus.blank_lz = 1'b1;
        drain(32);

        // Blanking off: tens and hundreds show 0.
        bus.blank_lz = 1'b0;
        push_frame(P7, P0, P0, 1'b0, 1'b0, 1'b1);
        drain(32);

        // Load 123 mid-ACTIVE of idx1: idx1 keeps the old 0, idx2 picks up the new 1.
        push_frame(P7, P0, P1, 1'b0, 1'b0, 1'b1);
        push_frame(P3, P2, P1, 1'b0, 1'b0, 1'b1);
        drain(12);
        bus.bcd_in = 10'b01_0010_0011;
        bus.load   = 1'b1;
        drain(52);

        // Non-decimal tens/ones nibbles render as dashes.
        push_frame(DASH, DASH, P0, 1'b0, 1'b0, 1'b1);
        bus.bcd_in = 10'b00_1111_1100;
        bus.load   = 1'b1;
        drain(32);

        // Async reset while idx1 is lit.
        push_frame(DASH, DASH, P0, 1'b0, 1'b0, 1'b1);
        drain(12);
        sb.delete();
        #1 rst_n = 1'b0;
        #1 check("async_reset", {bus.an, bus.seg, bus.dp, bus.frame_done}, {4'hF, OFF, 1'b1, 1'b0});
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        push_frame(P0, P0, P0, 1'b0, 1'b0, 1'b0);
        push_frame(P0, P0, P0, 1'b0, 1'b0, 1'b1);
        drain(64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
